onehot_arbiter: RTL and testbench

Round-robin arbiter that produces the registered one-hot select vector driving a `onehot_mux`, i.e. the requester-facing end of the one-hot select interface. It accepts one request line per source, grants exactly one source at a time, and holds the grant while the owner keeps requesting, up to a configurable burst limit. It also outputs the binary index of the owner for logging and bus tagging.

---
 rtl/arbiter_pkg.sv | 22 ++
 rtl/onehot_encoder.sv | 24 ++
 rtl/onehot_arbiter.sv | 154 +++++++++++++++
 tb/tb_onehot_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types, constants and helpers for the one-hot round-robin arbiter.
package arbiter_pkg;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    IDLE,
    OWNED
  } state_t;

  // Width of the per-ownership hold counter; it saturates at its maximum.
  localparam int unsigned CntWidth = 8;
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  // Binary index width for a given number of requesters, never below 1.
  function automatic int unsigned index_width(input int unsigned count);
    if ($clog2(count) < 1) begin
      return 1;
    end
    return $clog2(count);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder. An all-zero input yields index 0 and valid 0.
module onehot_encoder
  import arbiter_pkg::*;
#(
  parameter int unsigned Count = 4,
  localparam int unsigned IndexWidth = index_width(Count)
) (
  input  logic [Count-1:0]      onehot,
  output logic [IndexWidth-1:0] index,
  output logic                  valid
);

  // OR together the indices of all set bits; exact for a one-hot input.
  always_comb begin
    index = '0;
    for (int i = 0; i < Count; i++) begin
      if (onehot[i]) begin
        index = index | IndexWidth'(i);
      end
    end
    valid = |onehot;
  end

endmodule

// File: rtl/onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant, its valid flag and
// its binary index. The owner keeps the grant while it requests, up to MaxHold
// consecutive cycles (0 = unlimited), then the bus is re-arbitrated.
module onehot_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned Count = 4,
  parameter int unsigned MaxHold = 0,
  localparam int unsigned IndexWidth = index_width(Count)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [Count-1:0]      request,
  output logic [Count-1:0]      grant,
  output logic                  grant_valid,
  output logic [IndexWidth-1:0] grant_index
);

  localparam logic [IndexWidth-1:0] LastInit = IndexWidth'(Count - 1);
  localparam logic [CntWidth-1:0] HoldLimit = CntWidth'(MaxHold);
  localparam logic HoldLimited = (MaxHold != 0);
  localparam logic [Count-1:0] OneLsb = Count'(1);

  state_t                  state_q, state_d;
  logic [IndexWidth-1:0]   last_q, last_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [Count-1:0]        grant_q, grant_d;
  logic                    grant_valid_q;
  logic [IndexWidth-1:0]   grant_index_q;

  logic [IndexWidth-1:0]   start;
  logic [2*Count-1:0]      req_dbl;
  logic [Count-1:0]        req_rot;
  logic [Count-1:0]        pick_rot;
  logic [2*Count-1:0]      pick_dbl;
  logic [Count-1:0]        winner;
  logic                    winner_found;
  logic                    owner_req;
  logic                    limit_hit;
  logic                    keep;

  logic [IndexWidth-1:0]   next_index;
  logic                    next_valid;

  // Search origin is the slot after the last owner, wrapping at Count-1.
  always_comb begin
    if (last_q == LastInit) begin
      start = '0;
    end else begin
      start = last_q + IndexWidth'(1);
    end
  end

  // Rotate requests so the search origin lands at bit 0 and pick the lowest
  // set bit; an X request bit never qualifies, so the pick stays single-hot.
  always_comb begin
    req_dbl  = {request, request};
    req_rot  = Count'(req_dbl >> start);
    pick_rot = '0;
    for (int i = Count - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_rot = OneLsb << i;
      end
    end
    // Rotate the pick back to absolute request positions.
    pick_dbl     = {pick_rot, pick_rot};
    winner       = Count'(pick_dbl >> (Count - start));
    winner_found = |winner;
  end

  // Decide whether the current owner keeps the bus this edge.
  always_comb begin
    owner_req = |(request & grant_q);
    limit_hit = HoldLimited && (cnt_q == HoldLimit);
    keep      = (state_q == OWNED) && owner_req && !limit_hit;
  end

  // Next-state logic for ownership, grant vector and hold counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d = OWNED;
          grant_d = winner;
          cnt_d   = CntWidth'(1);
        end
      end
      OWNED: begin
        if (keep) begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end else if (winner_found) begin
          // Former owner is searched last, so it only wins when alone.
          grant_d = winner;
          cnt_d   = CntWidth'(1);
        end else begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  onehot_encoder #(
    .Count (Count)
  ) u_grant_enc (
    .onehot (grant_d),
    .index  (next_index),
    .valid  (next_valid)
  );

  // Pointer follows the next owner; it is left alone when going idle.
  always_comb begin
    if (next_valid) begin
      last_d = next_index;
    end else begin
      last_d = last_q;
    end
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= LastInit;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= next_valid;
      grant_index_q <= next_index;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;

endmodule

// File: tb/tb_onehot_arbiter.sv
// Directed bench for onehot_arbiter: one instance with unlimited hold, one with
// MaxHold=3, plus a random phase compared against a small behavioural model.
module tb_onehot_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic       valid_a, valid_b;
  logic [1:0] idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  // Reference model state for the MaxHold=3 instance.
  logic [3:0] m_grant;
  logic [1:0] m_last;
  int         m_cnt;

  always #5 clk = ~clk;

  onehot_arbiter #(
    .Count   (4),
    .MaxHold (0)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .request     (req_a),
    .grant       (grant_a),
    .grant_valid (valid_a),
    .grant_index (idx_a)
  );

  onehot_arbiter #(
    .Count   (4),
    .MaxHold (3)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .request     (req_b),
    .grant       (grant_b),
    .grant_valid (valid_b),
    .grant_index (idx_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    if (g[1]) r = 2'd1;
    if (g[2]) r = 2'd2;
    if (g[3]) r = 2'd3;
    return r;
  endfunction

  // Per-cycle invariants on one instance's outputs.
  task automatic props(input string tag, input logic [3:0] g, input logic v,
                       input logic [1:0] idx);
    check({tag, "_onehot"}, 32'((g & (g - 4'd1)) == 4'd0), 32'd1);
    check({tag, "_valid"}, 32'(v), 32'(g != 4'd0));
    check({tag, "_index"}, 32'(idx), 32'(enc(g)));
  endtask

  // One edge of the MaxHold=3 model, given the request seen at that edge.
  task automatic model_step(input logic [3:0] req);
    bit found;
    int w;
    if (m_grant != 4'd0 && (req & m_grant) != 4'd0 && m_cnt != 3) begin
      if (m_cnt < 255) m_cnt++;
    end else begin
      found = 1'b0;
      w = 0;
      for (int i = 1; i <= 4; i++) begin
        if (!found && req[(int'(m_last) + i) % 4]) begin
          found = 1'b1;
          w = (int'(m_last) + i) % 4;
        end
      end
      if (found) begin
        m_grant = 4'b0001 << w;
        m_last  = 2'(w);
        m_cnt   = 1;
      end else begin
        m_grant = 4'd0;
        m_cnt   = 0;
      end
    end
  endtask

  logic [3:0] rr_req [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0111};
  logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_b   [4] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100};
  logic [3:0] lone_b [10] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100};

  initial begin
    reset = 1'b1;
    req_a = 4'b1111;
    req_b = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant_a", 32'(grant_a), 32'h0);
    check("rst_valid_a", 32'(valid_a), 32'h0);
    check("rst_index_a", 32'(idx_a), 32'h0);
    check("rst_grant_b", 32'(grant_b), 32'h0);

    reset = 1'b0;
    step();
    check("first_grant_a", 32'(grant_a), 32'h1);
    check("first_index_a", 32'(idx_a), 32'h0);
    check("first_valid_a", 32'(valid_a), 32'h1);
    check("first_grant_b", 32'(grant_b), 32'h1);

    // Asynchronous reset in the middle of a cycle while owned.
    #2;
    reset = 1'b1;
    #1;
    check("async_grant_a", 32'(grant_a), 32'h0);
    check("async_valid_a", 32'(valid_a), 32'h0);
    check("async_grant_b", 32'(grant_b), 32'h0);
    reset = 1'b0;
    step();
    check("post_rst_grant_a", 32'(grant_a), 32'h1);
    check("post_rst_grant_b", 32'(grant_b), 32'h1);

    // Round-robin with the owner dropping one cycle after its grant.
    for (int k = 0; k < 4; k++) begin
      req_a = rr_req[k];
      step();
      check($sformatf("rr_grant_a_%0d", k), 32'(grant_a), 32'(rr_exp[k]));
      check($sformatf("rr_index_a_%0d", k), 32'(idx_a), 32'(enc(rr_exp[k])));
      check($sformatf("hold_grant_b_%0d", k), 32'(grant_b), 32'(rr_b[k]));
    end

    // Lone requester with unlimited hold; instance b exercises hold restart.
    req_a = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("lone_grant_a_%0d", k), 32'(grant_a), 32'h8);
      check($sformatf("lone_index_a_%0d", k), 32'(idx_a), 32'h3);
      check($sformatf("regrant_b_%0d", k), 32'(grant_b), 32'(lone_b[k]));
      if (k == 1) req_b = 4'b0001;
      if (k == 5) req_b = 4'b0101;
    end

    req_a = 4'b0000;
    step();
    check("drop_grant_a", 32'(grant_a), 32'h0);
    check("drop_valid_a", 32'(valid_a), 32'h0);
    check("drop_index_a", 32'(idx_a), 32'h0);

    // Wrap-around from last owner 3, then handover 0 -> 3 -> 0 with no gap.
    req_a = 4'b1001;
    step();
    check("wrap_grant_a", 32'(grant_a), 32'h1);
    req_a = 4'b1000;
    step();
    check("hand_grant_a", 32'(grant_a), 32'h8);
    check("hand_index_a", 32'(idx_a), 32'h3);
    req_a = 4'b0001;
    step();
    check("hand_back_a", 32'(grant_a), 32'h1);
    check("hand_back_index_a", 32'(idx_a), 32'h0);

    // Random phase from a fresh reset, model tracks instance b.
    #2;
    reset = 1'b1;
    #1;
    check("rand_rst_grant_b", 32'(grant_b), 32'h0);
    reset   = 1'b0;
    m_grant = 4'd0;
    m_last  = 2'd3;
    m_cnt   = 0;
    for (int k = 0; k < 300; k++) begin
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      model_step(req_b);
      step();
      check($sformatf("model_grant_b_%0d", k), 32'(grant_b), 32'(m_grant));
      props("rand_a", grant_a, valid_a, idx_a);
      props("rand_b", grant_b, valid_b, idx_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
